// File: rtl/wb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// wb_cache_ctrl
//
// N-way set-associative write-back cache controller with one data word per
// line. It sits between a core's load/store path and a backing memory (or a
// bus bridge). It provides dirty-victim writeback and true-LRU replacement.
//
// Handshake rule, used on both request channels: a transfer happens on a
// rising edge where valid and ready are both high. A source holds valid and
// its payload steady until that edge. A sink may raise ready at any time.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   CPU request channel; ready is high only in IDLE
//   req_write         1 = store, 0 = load
//   req_addr/wdata    byte address (bits [1:0] ignored) and store data
//   resp_valid        one-cycle response pulse
//   resp_hit          request hit in the cache (qualified by resp_valid)
//   resp_rdata        load data (meaningful on read responses)
//   mem_req_*         memory request: writeback (write=1) or fill (write=0)
//   mem_resp_valid    fill data present on mem_resp_rdata
//   stat_*            saturating hit/miss/writeback counters (optional)
//   dbg_state         current controller state, for debug/checkers
//
// Optional feature: define CACHE_STATS_EN to add stat_hits, stat_misses and
// stat_wbacks.
// -----------------------------------------------------------------------------
module wb_cache_ctrl #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
`ifdef CACHE_STATS_EN
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbacks,
`endif
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [WAY_W-1:0] MAX_AGE = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAG  = 3'd1,
        S_WB   = 3'd2,
        S_FILL = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched request (word address only; the byte offset is never used)
    logic              req_write_q;
    logic [ADDR_W-3:0] req_waddr_q;
    logic [DATA_W-1:0] req_wdata_q;

    logic [WAY_W-1:0]  victim_q;
    logic              fill_acc_q;   // fill request already taken by memory
    logic              resp_valid_q;
    logic              resp_hit_q;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    // Line storage
    logic              valid_q [NUM_SETS][NUM_WAYS];
    logic              dirty_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0] data_q  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic [WAY_W-1:0]  lru_age;

    // Line write / LRU touch controls produced by the FSM
    logic              line_we;
    logic [WAY_W-1:0]  line_way;
    logic              line_dirty;
    logic [DATA_W-1:0] line_data;
    logic              touch_en;
    logic [WAY_W-1:0]  touch_way;
    logic [WAY_W-1:0]  touch_old;
    logic [WAY_W-1:0]  new_age [NUM_WAYS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign idx     = req_waddr_q[IDX_W-1:0];
    assign req_tag = req_waddr_q[ADDR_W-3 -: TAG_W];

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise oldest way (lowest index
    // on equal ages). The second loop runs downward so the lowest invalid
    // way is the one that remains selected.
    always_comb begin
        victim_way = '0;
        lru_age    = age_q[idx][0];
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (age_q[idx][w] > lru_age) begin
                lru_age    = age_q[idx][w];
                victim_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    // LRU ages after touching touch_way. An invalid way being filled counts
    // as the oldest, so every valid way ages by one. This keeps the ages of
    // the valid ways a strict recency order.
    always_comb begin
        touch_old = valid_q[idx][touch_way] ? age_q[idx][touch_way] : MAX_AGE;
        for (int w = 0; w < NUM_WAYS; w++) begin
            new_age[w] = age_q[idx][w];
            if (WAY_W'(w) == touch_way) begin
                new_age[w] = '0;
            end else if (valid_q[idx][w] && (age_q[idx][w] < touch_old) &&
                         (age_q[idx][w] != MAX_AGE)) begin
                new_age[w] = age_q[idx][w] + WAY_W'(1);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        line_we       = 1'b0;
        line_way      = victim_q;
        line_dirty    = 1'b0;
        line_data     = req_wdata_q;
        touch_en      = 1'b0;
        touch_way     = victim_q;
        resp_rdata_d  = resp_rdata_q;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_TAG;
                end
            end

            S_TAG: begin
                if (hit) begin
                    touch_en  = 1'b1;
                    touch_way = hit_way;
                    state_d   = S_RESP;
                    if (req_write_q) begin
                        line_we    = 1'b1;
                        line_way   = hit_way;
                        line_dirty = 1'b1;
                    end else begin
                        resp_rdata_d = data_q[idx][hit_way];
                    end
                end else if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
                    state_d = S_WB;
                end else if (req_write_q) begin
                    // Full-word store: the line can be installed without a fill
                    line_we    = 1'b1;
                    line_way   = victim_way;
                    line_dirty = 1'b1;
                    touch_en   = 1'b1;
                    touch_way  = victim_way;
                    state_d    = S_RESP;
                end else begin
                    state_d = S_FILL;
                end
            end

            S_WB: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {tag_q[idx][victim_q], idx, 2'b00};
                mem_req_wdata = data_q[idx][victim_q];
                if (mem_req_ready) begin
                    if (req_write_q) begin
                        line_we    = 1'b1;
                        line_dirty = 1'b1;
                        touch_en   = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (!fill_acc_q) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {req_waddr_q, 2'b00};
                end
                // Fill data may arrive in the same cycle the request is taken
                if (mem_resp_valid && (fill_acc_q || mem_req_ready)) begin
                    line_we      = 1'b1;
                    line_dirty   = 1'b0;
                    line_data    = mem_resp_rdata;
                    touch_en     = 1'b1;
                    resp_rdata_d = mem_resp_rdata;
                    state_d      = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_write_q  <= 1'b0;
            req_waddr_q  <= '0;
            req_wdata_q  <= '0;
            victim_q     <= '0;
            fill_acc_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && req_valid) begin
                req_write_q <= req_write;
                req_waddr_q <= req_addr[ADDR_W-1:2];
                req_wdata_q <= req_wdata;
            end
            if (state_q == S_TAG) begin
                victim_q <= victim_way;
            end
            fill_acc_q   <= (state_q == S_FILL) && (fill_acc_q || mem_req_ready);
            resp_valid_q <= (state_d == S_RESP);
            resp_hit_q   <= (state_q == S_TAG) && hit;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Valid / dirty / age: cleared on reset, so dirty data is discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            if (touch_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[idx][w] <= new_age[w];
                end
            end
            if (line_we) begin
                valid_q[idx][line_way] <= 1'b1;
                dirty_q[idx][line_way] <= line_dirty;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q qualifies them
    always_ff @(posedge clk) begin
        if (!reset && line_we) begin
            tag_q[idx][line_way]  <= req_tag;
            data_q[idx][line_way] <= line_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q, stat_wbacks_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_wbacks_q <= '0;
        end else begin
            if ((state_q == S_TAG) && hit && (stat_hits_q != '1)) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if ((state_q == S_TAG) && !hit && (stat_misses_q != '1)) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
            if ((state_q == S_WB) && mem_req_ready && (stat_wbacks_q != '1)) begin
                stat_wbacks_q <= stat_wbacks_q + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_wbacks = stat_wbacks_q;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_cache_ctrl
//
// Directed steps followed by random traffic against wb_cache_ctrl. The
// reference model keeps each set as a recency-ordered list of lines
// (most recent first) plus a sparse backing memory. The bench plays the
// memory side with configurable accept and fill delays.
// -----------------------------------------------------------------------------
module tb_wb_cache_ctrl;

    localparam int NSETS = 16;
    localparam int NWAYS = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_hit;
    logic [DW-1:0] resp_rdata;
    logic          mem_req_valid, mem_req_ready, mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;
    logic [2:0]    dbg_state;
`ifdef CACHE_STATS_EN
    logic [31:0]   stat_hits, stat_misses, stat_wbacks;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_cache_ctrl #(
        .NUM_SETS(NSETS), .NUM_WAYS(NWAYS), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
`ifdef CACHE_STATS_EN
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
        .stat_wbacks    (stat_wbacks),
`endif
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_tests;
    int n_fail;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] data;
        logic        dirty;
    } line_t;

    line_t       sets [NSETS][$];
    logic [31:0] bmem [logic [31:0]];
    int          m_hits, m_misses, m_wbs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory content: written-back data if any, otherwise an address pattern
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return 32'hCAFE_0000 ^ a;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++) sets[s].delete();
        m_hits = 0;
        m_misses = 0;
        m_wbs = 0;
    endtask

    task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic e_hit, output logic [31:0] e_rd,
                                output logic e_wb, output logic [31:0] e_wba, output logic [31:0] e_wbd,
                                output logic e_fill, output logic [31:0] e_fa);
        int          s;
        int          pos;
        logic [31:0] wa;
        line_t       ln;
        s = int'((addr >> 2) % NSETS);
        wa = {addr[31:2], 2'b00};
        pos = -1;
        e_hit = 0; e_rd = 0; e_wb = 0; e_wba = 0; e_wbd = 0; e_fill = 0; e_fa = 0;
        for (int i = 0; i < sets[s].size(); i++) begin
            if (sets[s][i].waddr == wa) pos = i;
        end
        if (pos >= 0) begin
            m_hits++;
            ln = sets[s][pos];
            sets[s].delete(pos);
            e_hit = 1;
            if (wr) begin
                ln.data = wdata;
                ln.dirty = 1;
            end
            e_rd = ln.data;
        end else begin
            m_misses++;
            if (sets[s].size() == NWAYS) begin
                ln = sets[s].pop_back();
                if (ln.dirty) begin
                    e_wb = 1; e_wba = ln.waddr; e_wbd = ln.data;
                    bmem[ln.waddr] = ln.data;
                    m_wbs++;
                end
            end
            ln.waddr = wa;
            if (wr) begin
                ln.data = wdata;
                ln.dirty = 1;
            end else begin
                ln.data = mem_rd(wa);
                ln.dirty = 0;
                e_fill = 1; e_fa = wa; e_rd = ln.data;
            end
        end
        sets[s].push_front(ln);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One CPU transaction, with the memory side served by the bench
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int rdly, input int fdly);
        logic        e_hit, e_wb, e_fill;
        logic [31:0] e_rd, e_wba, e_wbd, e_fa;
        logic        o_hit;
        logic [31:0] o_rd, o_wba, o_wbd, o_fa;
        logic [31:0] c_addr, c_wdata;
        logic        c_write;
        int          nwb, nfill, lat, wait_c, fill_wait;
        bit          in_req, fill_pend, got, stable;

        model_access(wr, addr, wdata, e_hit, e_rd, e_wb, e_wba, e_wbd, e_fill, e_fa);
        nwb = 0; nfill = 0; lat = 0; wait_c = 0; fill_wait = 0;
        in_req = 0; fill_pend = 0; got = 0; stable = 1;
        o_hit = 0; o_rd = 0; o_wba = 0; o_wbd = 0; o_fa = 0;
        c_addr = 0; c_wdata = 0; c_write = 0;

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            mem_req_ready = 0;
            mem_resp_valid = 0;
            mem_resp_rdata = $urandom;
            // Request lines carry junk while busy; the controller must ignore it
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr = $urandom;
            req_wdata = $urandom;
            if (resp_valid) begin
                req_valid = 0;
                got = 1; o_hit = resp_hit; o_rd = resp_rdata; lat = cyc;
                break;
            end
            if (mem_req_valid) begin
                if (!in_req) begin
                    in_req = 1; wait_c = 0;
                    c_addr = mem_req_addr; c_wdata = mem_req_wdata; c_write = mem_req_write;
                end else if (mem_req_addr !== c_addr || mem_req_wdata !== c_wdata ||
                             mem_req_write !== c_write) begin
                    stable = 0;
                end
                if (wait_c >= rdly) begin
                    mem_req_ready = 1;
                    in_req = 0;
                    if (c_write) begin
                        nwb++; o_wba = c_addr; o_wbd = c_wdata;
                    end else begin
                        nfill++; o_fa = c_addr; fill_pend = 1; fill_wait = 0;
                    end
                end
                wait_c++;
            end
            if (fill_pend) begin
                if (fill_wait >= fdly) begin
                    mem_resp_valid = 1;
                    mem_resp_rdata = mem_rd(o_fa);
                    fill_pend = 0;
                end else begin
                    fill_wait++;
                end
            end
        end
        req_valid = 0;
        mem_req_ready = 0;
        mem_resp_valid = 0;

        check("txn_done", got, 1);
        check("resp_hit", o_hit, e_hit);
        if (!wr) check("resp_rdata", o_rd, e_rd);
        if (e_hit) check("hit_latency", lat, 2);
        check("wb_count", nwb, e_wb);
        if (e_wb) begin
            check("wb_addr", o_wba, e_wba);
            check("wb_data", o_wbd, e_wbd);
        end
        check("fill_count", nfill, e_fill);
        if (e_fill) check("fill_addr", o_fa, e_fa);
        check("mem_req_stable", stable, 1);
    endtask

    // Read miss into an empty set, then reset while the fill is outstanding
    task automatic reset_during_fill(input logic [31:0] addr, input bit accept);
        bit seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = addr; req_wdata = 0;
        @(posedge clk);
        #1 req_valid = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_req_valid && !mem_req_write) seen = 1;
        end
        check("rstfill_req_seen", seen, 1);
        check("rstfill_req_addr", mem_req_addr, {addr[31:2], 2'b00});
        if (accept) begin
            mem_req_ready = 1;
            @(negedge clk);
            mem_req_ready = 0;
            check("rstfill_req_dropped", mem_req_valid, 0);
        end
        check("rstfill_busy", req_ready, 0);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("rstfill_mem_valid", mem_req_valid, 0);
        check("rstfill_req_ready", req_ready, 1);
        check("rstfill_resp_valid", resp_valid, 0);
        reset = 0;
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, tv;
        n_tests = 0;
        n_fail = 0;
        reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        model_clear();

        do_reset();
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_write", mem_req_write, 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_mem_wdata", mem_req_wdata, 0);

        // Cold read miss with a 3-cycle fill, then the same line hits
        run_txn(0, 32'h000, 32'h0, 0, 3);
        run_txn(0, 32'h000, 32'h0, 1, 1);

        // Four write misses into set 0 need no memory traffic; then a read hit
        do_reset();
        run_txn(1, 32'h000, 32'hDEAD_0000, 0, 0);
        run_txn(1, 32'h040, 32'hDEAD_0010, 0, 0);
        run_txn(1, 32'h080, 32'hDEAD_0020, 0, 0);
        run_txn(1, 32'h0C0, 32'hDEAD_0030, 0, 0);
        run_txn(0, 32'h040, 32'h0, 0, 0);

        // Dirty LRU victim writeback held off for 5 cycles
        run_txn(1, 32'h100, 32'hBEEF_0000, 5, 0);
        run_txn(0, 32'h100, 32'h0, 0, 0);
        run_txn(0, 32'h002, 32'h0, 2, 2);

        // Reset with fill request pending, and with fill accepted but unanswered
        reset_during_fill(32'h014, 0);
        run_txn(0, 32'h100, 32'h0, 0, 1);
        run_txn(0, 32'h040, 32'h0, 1, 0);
        reset_during_fill(32'h214, 1);
        run_txn(0, 32'h100, 32'h0, 0, 0);

        // Random traffic over 4 sets and 6 tags (one near the top of memory)
        for (int i = 0; i < 300; i++) begin
            tv = 32'($urandom_range(0, 5));
            if (tv == 5) tv = 32'h03FF_FFFF;
            a = (tv << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            run_txn(1'($urandom_range(0, 1)), a, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stat_hits", stat_hits, m_hits);
        check("stat_misses", stat_misses, m_misses);
        check("stat_wbacks", stat_wbacks, m_wbs);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
